// File: rtl/rua_run_ctrl.sv
// Run controller for the rua core: holds the core in reset, runs it, and ends the run
// on a tohost store, a self-loop (`j .`) or a cycle-limit timeout.
module rua_run_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_00FC,
    parameter int              MAX_CYCLES  = 1000,
    parameter int              RESET_HOLD  = 1,
    parameter int              STALL_LIMIT = 4,
    parameter int              CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 core_rst,
    input  logic                 retire,
    input  logic [XLEN-1:0]      retire_pc,
    input  logic                 mem_we,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN-1:0]      mem_wdata,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic [1:0]           reason,
    output logic [XLEN-1:0]      exit_code,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);
    localparam int SAME_W = $clog2(STALL_LIMIT + 1);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [XLEN-1:0]     last_pc_reg;
    logic [SAME_W-1:0]   same_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;

    logic pc_match;
    logic hit_tohost;
    logic hit_loop;
    logic hit_timeout;

    // Termination conditions look at the values registered before this RUN edge.
    assign pc_match    = retire && (retire_pc == last_pc_reg);
    assign hit_tohost  = mem_we && (mem_addr == TOHOST_ADDR);
    assign hit_loop    = pc_match && (same_cnt_reg == SAME_W'(STALL_LIMIT - 1));
    assign hit_timeout = (cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            reason       <= 2'd0;
            exit_code    <= '0;
            cycle_cnt    <= '0;
            retire_cnt   <= '0;
            last_pc_reg  <= '0;
            same_cnt_reg <= '0;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg    <= HOLD;
                        core_rst     <= 1'b1;
                        running      <= 1'b0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        reason       <= 2'd0;
                        exit_code    <= '0;
                        cycle_cnt    <= '0;
                        retire_cnt   <= '0;
                        last_pc_reg  <= '0;
                        same_cnt_reg <= '0;
                        hold_cnt_reg <= HOLD_W'(RESET_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_reg <= RUN;
                        core_rst  <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
                    end
                    if (retire && (retire_cnt != '1)) begin
                        retire_cnt <= retire_cnt + CNT_WIDTH'(1);
                    end
                    if (pc_match) begin
                        same_cnt_reg <= same_cnt_reg + SAME_W'(1);
                    end else if (retire) begin
                        same_cnt_reg <= SAME_W'(1);
                        last_pc_reg  <= retire_pc;
                    end
                    if (hit_tohost || hit_loop || hit_timeout) begin
                        state_reg <= DONE;
                        core_rst  <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        if (hit_tohost) begin
                            reason    <= 2'd1;
                            exit_code <= mem_wdata >> 1;
                            pass      <= (mem_wdata == XLEN'(1));
                        end else if (hit_loop) begin
                            reason <= 2'd2;
                            pass   <= 1'b1;
                        end else begin
                            reason <= 2'd3;
                            pass   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    core_rst  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/rua_run_ctrl.md
Name: rua_run_ctrl

Overview:
Synthesisable run controller and end-of-test monitor placed beside the rua core in the top-level harness.
- Drives the core's active-high reset.
- Releases the core after a programmable hold period and counts cycles and retired instructions.
- Ends the run on one of three events: a write to a tohost address, a self-loop (program parked in `j .`), or a cycle-limit timeout.
- Reports pass/fail, exit code and reason, replacing fixed-length simulation loops.

Parameters:
XLEN, 32, data/PC width
TOHOST_ADDR, 32'h0000_00FC, store address that terminates the run
MAX_CYCLES, 1000, RUN-cycle limit before timeout (>=1)
RESET_HOLD, 1, cycles core_rst is held in HOLD (>=1)
STALL_LIMIT, 4, consecutive same-PC retires declaring a self-loop (>=2)
CNT_WIDTH, 32, width of cycle/retire counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset of this block
start  in  1  pulse; begins a run from IDLE or DONE
core_rst  out  1  active-high reset to the core
retire  in  1  core retired one instruction this cycle
retire_pc  in  XLEN  PC of the retired instruction
mem_we  in  1  core data-memory write strobe
mem_addr  in  XLEN  core data-memory write address
mem_wdata  in  XLEN  core data-memory write data
running  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  run verdict, valid while done
reason  out  2  0 none, 1 tohost, 2 self-loop, 3 timeout
exit_code  out  XLEN  tohost data >> 1, zero-extended
cycle_cnt  out  CNT_WIDTH  RUN cycles elapsed
retire_cnt  out  CNT_WIDTH  instructions retired in RUN

Behaviour:
- Async reset (rst=0): state IDLE, core_rst=1; running, done, pass, reason, exit_code, cycle_cnt, retire_cnt all 0; internal last_pc=0, same_cnt=0, hold_cnt=0.
- All outputs are registered.
- States: IDLE, HOLD, RUN, DONE.
- IDLE:
  - core_rst=1.
  - start=1 -> HOLD; clear all counters and result outputs.
  - hold_cnt loads RESET_HOLD-1.
- HOLD:
  - core_rst=1.
  - hold_cnt decrements each cycle; at 0 -> RUN.
  - core_rst is therefore high for exactly RESET_HOLD cycles after the start edge.
  - start is ignored.
- RUN:
  - core_rst=0, running=1.
  - Every cycle, cycle_cnt+1; retire=1 -> retire_cnt+1.
  - Both counters saturate at all-ones.
  - start is ignored.
- Self-loop tracking (RUN only, on retire=1):
  - retire_pc==last_pc: same_cnt+1.
  - Otherwise: same_cnt=1 and last_pc=retire_pc.
- Termination checks are evaluated every RUN cycle. On termination: next state DONE, running=0, done=1 and results registered on the same edge. Counters include the terminating cycle.
  - Priority: tohost > self-loop > timeout.
  - tohost: mem_we && mem_addr==TOHOST_ADDR. Sets reason=1, exit_code=mem_wdata>>1, pass=(mem_wdata==1).
  - self-loop: retire && retire_pc==last_pc && same_cnt==STALL_LIMIT-1. Sets reason=2, pass=1, exit_code=0.
  - timeout: cycle_cnt==MAX_CYCLES-1. Sets reason=3, pass=0, exit_code=0; cycle_cnt shows MAX_CYCLES in DONE.
- DONE:
  - core_rst=1 to freeze the core.
  - All outputs hold.
  - start=1 -> HOLD with all results and counters cleared, as from IDLE.
- rst asserted in any state, including mid-RUN: immediate return to reset values; core_rst goes high asynchronously.
- mem_we and retire are ignored outside RUN.

Test Plan:
1. Reset and idle: hold rst=0 for 3 cycles, release with start=0 for 5 cycles -> core_rst=1, running=0, done=0, cycle_cnt=0, reason=0 throughout.
2. Hold timing (RESET_HOLD=3): pulse start -> core_rst stays 1 for exactly 3 cycles after the start edge, then 0 with running=1; a second start during HOLD or RUN has no effect.
3. tohost pass: in RUN, retire every cycle; write mem_addr=0xFC, mem_wdata=1 in the 10th RUN cycle -> next cycle done=1, pass=1, reason=1, exit_code=0, cycle_cnt=10, retire_cnt=10, core_rst=1. Repeat with mem_wdata=7 -> pass=0, exit_code=3. A write to 0xF8 is ignored.
4. Self-loop (STALL_LIMIT=4): retire PCs 0x10, 0x14, then 0x40 four times -> done after the 4th 0x40 retire with reason=2, pass=1, retire_cnt=6. PCs 0x40, 0x40, 0x44, 0x40, 0x40, 0x40 do not trigger.
5. Timeout and priority (MAX_CYCLES=50):
   - No events -> done with reason=3, pass=0, cycle_cnt=50.
   - tohost write in RUN cycle 50 -> reason=1, not 3.
   - tohost write coinciding with the self-loop completion -> reason=1.
6. Restart and mid-run reset:
   - start in DONE -> results and counters clear, HOLD re-entered, a new run completes normally.
   - rst=0 asserted mid-RUN -> core_rst=1 and all outputs 0 without waiting for a clock edge.
